// File: rtl/single_cycle_mips_if.sv
// Instruction-fetch and data-SRAM bus between the core (master) and its memories (slave).
interface single_cycle_mips_if;
  logic [31:0] IR_addr;
  logic [31:0] IR;
  logic [31:0] RF_writedata;
  logic [31:0] ReadDataMem;
  logic        CEN;
  logic        WEN;
  logic [6:0]  A;
  logic [31:0] ReadData2;
  logic        OEN;

  modport master (
    output IR_addr, RF_writedata, CEN, WEN, A, ReadData2, OEN,
    input  IR, ReadDataMem
  );

  modport slave (
    input  IR_addr, RF_writedata, CEN, WEN, A, ReadData2, OEN,
    output IR, ReadDataMem
  );
endinterface

// File: rtl/single_cycle_mips.sv
// Single-cycle MIPS core: PC, 32x32 register file, ALU and decode; one instruction retires per rising clk.
// Data SRAM samples on the falling edge, so its read data is ready for the register write at the next rising edge.
module single_cycle_mips (
  input  logic                clk,
  input  logic                rst,
  single_cycle_mips_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] regs [32];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  wr_addr;
  logic        reg_write;
  logic        is_lw;
  logic        is_sw;
  logic        is_jal;

  assign op       = bus.IR[31:26];
  assign rs       = bus.IR[25:21];
  assign rt       = bus.IR[20:16];
  assign rd       = bus.IR[15:11];
  assign funct    = bus.IR[5:0];
  assign imm      = bus.IR[15:0];
  assign target   = bus.IR[25:0];
  assign sext     = {{16{imm[15]}}, imm};
  assign pc_plus4 = pc + 32'd4;

  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_jal = (op == OP_JAL);

  // $0 is never written, so a plain array read already returns zero for it.
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];

  always_comb begin
    alu_result = rs_val + sext;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_result = rs_val + rt_val;
        FN_SUB:  alu_result = rs_val - rt_val;
        FN_AND:  alu_result = rs_val & rt_val;
        FN_OR:   alu_result = rs_val | rt_val;
        FN_SLT:  alu_result = {31'd0, $signed(rs_val) < $signed(rt_val)};
        default: alu_result = rs_val + rt_val;
      endcase
    end else if (op == OP_BEQ) begin
      alu_result = rs_val - rt_val;
    end
  end

  // Decode: register write enable/destination and next PC; unknown encodings fall through as NOPs.
  always_comb begin
    reg_write = 1'b0;
    wr_addr   = rd;
    pc_next   = pc_plus4;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: reg_write = 1'b1;
          FN_JR:   pc_next = rs_val;
          default: reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        reg_write = 1'b1;
        wr_addr   = rt;
      end
      OP_BEQ: begin
        if (rs_val == rt_val) pc_next = pc_plus4 + {sext[29:0], 2'b00};
      end
      OP_J: begin
        pc_next = {pc_plus4[31:28], target, 2'b00};
      end
      OP_JAL: begin
        pc_next   = {pc_plus4[31:28], target, 2'b00};
        reg_write = 1'b1;
        wr_addr   = 5'd31;
      end
      default: reg_write = 1'b0;
    endcase
  end

  assign write_data = is_lw  ? bus.ReadDataMem :
                      is_jal ? pc_plus4        : alu_result;

  assign bus.IR_addr      = pc;
  assign bus.RF_writedata = write_data;
  assign bus.ReadData2    = rt_val;
  // Low 7 bits of the sum equal the sum of the low 7 bits: word address wraps modulo 128.
  assign bus.A            = rs_val[6:0] + imm[6:0];
  assign bus.CEN          = rst | ~(is_lw | is_sw);
  assign bus.WEN          = rst | ~is_sw;
  assign bus.OEN          = rst | ~is_lw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 32'd0;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (reg_write && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= write_data;
    end
  end
endmodule

// File: tb/tb_single_cycle_mips.sv
// Runs the canonical program plus NOP/signed/wrap/$zero extras against ROM and falling-edge SRAM models.
module tb_single_cycle_mips;
  typedef struct {
    logic [31:0] pc;
    int          kind;     // 0 = no memory access, 1 = lw, 2 = sw
    bit          chk_wd;
    logic [31:0] wd;
    logic [6:0]  a;
    bit          chk_rd2;
    logic [31:0] rd2;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] rom  [64];
  logic [31:0] sram [128];
  logic [31:0] q;
  vec_t        tbl  [27];
  vec_t        sb   [$];

  single_cycle_mips_if bus ();

  single_cycle_mips dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (bus.IR_addr < 32'd256) bus.IR = rom[bus.IR_addr[7:2]];
    else                       bus.IR = 32'd0;
  end

  always @(negedge clk) begin
    if (!bus.CEN) begin
      if (!bus.WEN) sram[bus.A] <= bus.ReadData2;
      else          q <= sram[bus.A];
    end
  end
  assign bus.ReadDataMem = q;

  function automatic logic [31:0] r_op(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                       input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                       input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic logic [31:0] j_op(input logic [5:0] o, input logic [25:0] tg);
    return {o, tg};
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input int kind, input bit chk_wd, input logic [31:0] wd,
                              input logic [6:0] a, input bit chk_rd2, input logic [31:0] rd2);
    vec_t v;
    v.pc = pc; v.kind = kind; v.chk_wd = chk_wd; v.wd = wd;
    v.a = a; v.chk_rd2 = chk_rd2; v.rd2 = rd2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops one expected retirement per cycle, sampled after the SRAM's falling-edge read.
  task automatic run_queue();
    vec_t        v;
    logic [2:0]  ctrl;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      @(negedge clk);
      #2;
      case (v.kind)
        1:       ctrl = 3'b010;
        2:       ctrl = 3'b001;
        default: ctrl = 3'b111;
      endcase
      check($sformatf("pc@%0d", v.pc), bus.IR_addr, v.pc);
      check($sformatf("cen_wen_oen@%0d", v.pc), {29'd0, bus.CEN, bus.WEN, bus.OEN}, {29'd0, ctrl});
      if (v.chk_wd)   check($sformatf("wd@%0d", v.pc), bus.RF_writedata, v.wd);
      if (v.kind != 0) check($sformatf("addr@%0d", v.pc), {25'd0, bus.A}, {25'd0, v.a});
      if (v.chk_rd2)  check($sformatf("rd2@%0d", v.pc), bus.ReadData2, v.rd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    q        = 32'd0;
    for (int i = 0; i < 128; i++) sram[i] = 32'd0;
    sram[0] = 32'd15;
    sram[1] = 32'd20;
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;

    rom[0]  = i_op(6'h23, 5'd0, 5'd8, 16'd0);       // lw $t0,0($zero)
    rom[1]  = i_op(6'h23, 5'd0, 5'd9, 16'd1);       // lw $t1,1($zero)
    rom[2]  = r_op(5'd8, 5'd8, 5'd8, 6'h20);        // add $t0,$t0,$t0
    rom[3]  = r_op(5'd8, 5'd9, 5'd10, 6'h22);       // sub $t2
    rom[4]  = r_op(5'd8, 5'd9, 5'd11, 6'h24);       // and $t3
    rom[5]  = i_op(6'h04, 5'd8, 5'd9, 16'd1);       // beq not taken
    rom[6]  = r_op(5'd8, 5'd9, 5'd12, 6'h25);       // or $t4
    rom[7]  = r_op(5'd11, 5'd12, 5'd13, 6'h2A);     // slt $t5,$t3,$t4
    rom[8]  = i_op(6'h2B, 5'd0, 5'd12, 16'd4);      // sw $t4,4($zero)
    rom[9]  = i_op(6'h23, 5'd0, 5'd17, 16'd4);      // lw $s1,4($zero)
    rom[10] = j_op(6'h02, 26'd13);                  // j 52
    rom[11] = r_op(5'd9, 5'd9, 5'd19, 6'h20);       // add $s3 = 40
    rom[12] = r_op(5'd31, 5'd0, 5'd0, 6'h08);       // jr $ra
    rom[13] = r_op(5'd11, 5'd11, 5'd18, 6'h20);     // add $s2 = 40
    rom[14] = j_op(6'h03, 26'd11);                  // jal 44
    rom[15] = i_op(6'h04, 5'd18, 5'd19, 16'd2);     // beq taken -> 72
    rom[16] = r_op(5'd8, 5'd8, 5'd20, 6'h20);       // skipped
    rom[17] = r_op(5'd8, 5'd8, 5'd20, 6'h20);       // skipped
    rom[18] = r_op(5'd18, 5'd19, 5'd20, 6'h20);     // add $s4 = 80
    rom[19] = r_op(5'd8, 5'd8, 5'd0, 6'h20);        // add $zero (dropped)
    rom[20] = r_op(5'd0, 5'd8, 5'd21, 6'h20);       // add $s5,$zero,$t0
    rom[21] = i_op(6'h08, 5'd8, 5'd8, 16'd5);       // addi: unsupported -> NOP
    rom[22] = r_op(5'd8, 5'd0, 5'd22, 6'h20);       // add $s6,$t0,$zero
    rom[23] = r_op(5'd8, 5'd8, 5'd8, 6'h27);        // nor: unsupported -> NOP
    rom[24] = r_op(5'd8, 5'd0, 5'd23, 6'h25);       // or $s7,$t0,$zero
    rom[25] = r_op(5'd9, 5'd8, 5'd14, 6'h22);       // sub $t6 = -10
    rom[26] = r_op(5'd14, 5'd8, 5'd15, 6'h2A);      // slt -10 < 30
    rom[27] = r_op(5'd8, 5'd14, 5'd15, 6'h2A);      // slt 30 < -10
    rom[28] = i_op(6'h23, 5'd0, 5'd24, 16'd129);    // lw 129 wraps to word 1

    tbl[0]  = mk(32'd0,   1, 1, 32'd15, 7'd0, 1, 32'd0);
    tbl[1]  = mk(32'd4,   1, 1, 32'd20, 7'd1, 0, 32'd0);
    tbl[2]  = mk(32'd8,   0, 1, 32'd30, 7'd0, 0, 32'd0);
    tbl[3]  = mk(32'd12,  0, 1, 32'd10, 7'd0, 0, 32'd0);
    tbl[4]  = mk(32'd16,  0, 1, 32'd20, 7'd0, 0, 32'd0);
    tbl[5]  = mk(32'd20,  0, 0, 32'd0,  7'd0, 1, 32'd20);
    tbl[6]  = mk(32'd24,  0, 1, 32'd30, 7'd0, 0, 32'd0);
    tbl[7]  = mk(32'd28,  0, 1, 32'd1,  7'd0, 0, 32'd0);
    tbl[8]  = mk(32'd32,  2, 0, 32'd0,  7'd4, 1, 32'd30);
    tbl[9]  = mk(32'd36,  1, 1, 32'd30, 7'd4, 0, 32'd0);
    tbl[10] = mk(32'd40,  0, 0, 32'd0,  7'd0, 0, 32'd0);
    tbl[11] = mk(32'd52,  0, 1, 32'd40, 7'd0, 0, 32'd0);
    tbl[12] = mk(32'd56,  0, 1, 32'd60, 7'd0, 0, 32'd0);
    tbl[13] = mk(32'd44,  0, 1, 32'd40, 7'd0, 0, 32'd0);
    tbl[14] = mk(32'd48,  0, 0, 32'd0,  7'd0, 0, 32'd0);
    tbl[15] = mk(32'd60,  0, 0, 32'd0,  7'd0, 0, 32'd0);
    tbl[16] = mk(32'd72,  0, 1, 32'd80, 7'd0, 0, 32'd0);
    tbl[17] = mk(32'd76,  0, 1, 32'd60, 7'd0, 0, 32'd0);
    tbl[18] = mk(32'd80,  0, 1, 32'd30, 7'd0, 0, 32'd0);
    tbl[19] = mk(32'd84,  0, 0, 32'd0,  7'd0, 0, 32'd0);
    tbl[20] = mk(32'd88,  0, 1, 32'd30, 7'd0, 0, 32'd0);
    tbl[21] = mk(32'd92,  0, 0, 32'd0,  7'd0, 0, 32'd0);
    tbl[22] = mk(32'd96,  0, 1, 32'd30, 7'd0, 0, 32'd0);
    tbl[23] = mk(32'd100, 0, 1, 32'hFFFF_FFF6, 7'd0, 0, 32'd0);
    tbl[24] = mk(32'd104, 0, 1, 32'd1,  7'd0, 0, 32'd0);
    tbl[25] = mk(32'd108, 0, 1, 32'd0,  7'd0, 0, 32'd0);
    tbl[26] = mk(32'd112, 1, 1, 32'd20, 7'd1, 0, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", bus.IR_addr, 32'd0);
    check("reset_ctrl", {29'd0, bus.CEN, bus.WEN, bus.OEN}, 32'd7);

    // Release while clk is high so the first falling edge serves the first lw.
    rst = 1'b0;
    for (int i = 0; i < 27; i++) sb.push_back(tbl[i]);
    run_queue();
    check("sram_word4", sram[4], 32'd30);

    // Asynchronous reset mid-cycle: PC and registers clear without waiting for a clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pc", bus.IR_addr, 32'd0);
    check("midrst_ctrl", {29'd0, bus.CEN, bus.WEN, bus.OEN}, 32'd7);
    check("midrst_t0_cleared", bus.ReadData2, 32'd0);
    @(negedge clk);
    #1;
    check("midrst_pc_held", bus.IR_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back(tbl[0]);
    sb.push_back(tbl[1]);
    sb.push_back(tbl[2]);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
